glip_uart_control_ingress: RTL

Ingress-path parser for the GLIP UART backend. Takes the raw byte stream from the UART receiver, removes the 0xfe escape encoding, and splits it into user data and credit messages. User data goes to the ingress FIFO through a one-entry output register. Decoded credit values go to the flow-control logic that gates the egress path.

---
 rtl/glip_uart_control_ingress.sv | 124 ++++++++++++
 1 files changed

// File: rtl/glip_uart_control_ingress.sv
// Ingress parser for the GLIP UART link: strips 0xfe escaping, forwards user
// bytes through a one-entry output register and decodes 15-bit credit messages.
module glip_uart_control_ingress (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        transfer,
  output logic [14:0] credit,
  output logic        credit_en,
  output logic        error
);

  localparam logic [1:0] STATE_IDLE      = 2'd0;
  localparam logic [1:0] STATE_ESCAPE    = 2'd1;
  localparam logic [1:0] STATE_CREDIT_LO = 2'd2;

  localparam logic [7:0] ESC_BYTE = 8'hfe;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [6:0] credit_hi;

  logic       push;
  logic [7:0] push_byte;
  logic       latch_hi;
  logic       credit_done;
  logic       proto_err;
  logic       overflow;
  logic       drain;

  // Byte classification; the parser only moves on an accepted strobe.
  always_comb begin
    state_next  = state;
    push        = 1'b0;
    push_byte   = in_data;
    latch_hi    = 1'b0;
    credit_done = 1'b0;
    proto_err   = 1'b0;
    if (in_enable) begin
      case (state)
        STATE_IDLE: begin
          if (in_data == ESC_BYTE) begin
            state_next = STATE_ESCAPE;
          end else begin
            push = 1'b1;
          end
        end
        STATE_ESCAPE: begin
          state_next = STATE_IDLE;
          if (in_data == ESC_BYTE) begin
            push = 1'b1;
          end else if (in_data[0]) begin
            latch_hi   = 1'b1;
            state_next = STATE_CREDIT_LO;
          end else begin
            proto_err = 1'b1;
          end
        end
        STATE_CREDIT_LO: begin
          // Low credit byte is taken verbatim, even if it is 0xfe.
          credit_done = 1'b1;
          state_next  = STATE_IDLE;
        end
        default: begin
          state_next = STATE_IDLE;
        end
      endcase
    end
  end

  assign drain    = out_valid & out_ready;
  assign overflow = push & out_valid & ~out_ready;
  assign transfer = drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_IDLE;
      credit_hi <= 7'd0;
    end else begin
      state <= state_next;
      if (latch_hi) begin
        credit_hi <= in_data[7:1];
      end
    end
  end

  // Output register: a push in the draining cycle replaces the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
    end else if (push && !overflow) begin
      out_data  <= push_byte;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit    <= 15'd0;
      credit_en <= 1'b0;
    end else begin
      credit_en <= credit_done;
      if (credit_done) begin
        credit <= {credit_hi, in_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= 1'b0;
    end else if (proto_err || overflow) begin
      error <= 1'b1;
    end
  end

endmodule
